// File: rtl/pio_pkg.sv
// Shared constants for the parameterised PIO: register map, edge-mode encodings
// and pulse FSM state type.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
  localparam logic [2:0] ADDR_OUT_REG  = 3'd6;
  localparam logic [2:0] ADDR_PULSE    = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int CNT_W = 16;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_edge_capture.sv
// Input synchroniser, edge detector and write-1-to-clear capture register.
module pio_edge_capture
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  w1c_en,
  input  logic [DATA_WIDTH-1:0] w1c_data,
  output logic [DATA_WIDTH-1:0] sync_data,
  output logic [DATA_WIDTH-1:0] edge_cap
);

  logic [DATA_WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] dly_p;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] cap_q;

  // synchroniser chain plus one delay flop for the detector
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      dly_p <= '0;
    end else begin
      sync_p[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      dly_p <= sync_p[SYNC_STAGES-1];
    end
  end

  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == EDGE_RISE)
      edge_det = sync_p[SYNC_STAGES-1] & ~dly_p;
    else if (EDGE_TYPE == EDGE_FALL)
      edge_det = ~sync_p[SYNC_STAGES-1] & dly_p;
    else if (EDGE_TYPE == EDGE_ANY)
      edge_det = sync_p[SYNC_STAGES-1] ^ dly_p;
  end

  // a fresh edge overrides a simultaneous clear of the same bit
  always_ff @(posedge clk) begin
    if (!reset_n)
      cap_q <= '0;
    else if (w1c_en)
      cap_q <= (cap_q & ~w1c_data) | edge_det;
    else
      cap_q <= cap_q | edge_det;
  end

  assign sync_data = sync_p[SYNC_STAGES-1];
  assign edge_cap  = cap_q;

endmodule

// File: rtl/param_pio.sv
// Avalon-MM parallel I/O with edge-capture interrupts and a self-timed output pulse.
module param_pio
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = EDGE_RISE,
  parameter int                    PULSE_LEN   = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unused_wdata;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] pulse_mask_q;
  logic [CNT_W-1:0]      cnt_q;
  pulse_state_e          state_q;
  logic [DATA_WIDTH-1:0] out_setclr;
  logic [DATA_WIDTH-1:0] sync_data;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic [DATA_WIDTH-1:0] rd_data;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  pio_edge_capture #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .w1c_en   (wr_en && (address == ADDR_EDGE_CAP)),
    .w1c_data (wdata),
    .sync_data(sync_data),
    .edge_cap (edge_cap)
  );

  always_comb begin
    out_setclr = out_q;
    if (wr_en && (address == ADDR_OUT_SET))
      out_setclr = out_q | wdata;
    else if (wr_en && (address == ADDR_OUT_CLR))
      out_setclr = out_q & ~wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      mask_q <= '0;
    else if (wr_en && (address == ADDR_IRQ_MASK))
      mask_q <= wdata;
  end

  // output register and pulse FSM; a retrigger takes priority over expiry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q        <= RESET_VALUE;
      pulse_mask_q <= '0;
      cnt_q        <= '0;
      state_q      <= PULSE_IDLE;
    end else if (wr_en && (address == ADDR_PULSE) && (|wdata)) begin
      out_q        <= out_q | wdata;
      pulse_mask_q <= pulse_mask_q | wdata;
      cnt_q        <= PULSE_LOAD;
      state_q      <= PULSE_ACTIVE;
    end else if (wr_en && (address == ADDR_DATA)) begin
      out_q        <= wdata;
      pulse_mask_q <= '0;
      cnt_q        <= '0;
      state_q      <= PULSE_IDLE;
    end else begin
      case (state_q)
        PULSE_ACTIVE: begin
          if (cnt_q == CNT_W'(1)) begin
            out_q        <= out_setclr & ~pulse_mask_q;
            pulse_mask_q <= '0;
            cnt_q        <= '0;
            state_q      <= PULSE_IDLE;
          end else begin
            out_q <= out_setclr;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: out_q <= out_setclr;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_DATA:     rd_data = sync_data;
      ADDR_IRQ_MASK: rd_data = mask_q;
      ADDR_EDGE_CAP: rd_data = edge_cap;
      ADDR_OUT_REG:  rd_data = out_q;
      default:       rd_data = '0;
    endcase
  end

  assign readdata = 32'(rd_data);
  assign out_port = out_q;
  assign irq      = |(edge_cap & mask_q);

endmodule
